// File: rtl/fp_addsub_serial.sv
// Word-serial (a +/- b) mod P: raw pass, then a +/-P correction pass,
// both through one shared W-bit carry adder.
module fp_word_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

module fp_addsub_serial #(
  parameter int WIDTH = 128,
  parameter int W = 32,
  parameter logic [WIDTH-1:0] P =
    128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done
);
  localparam int NW = WIDTH / W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  typedef enum logic [1:0] {
    IDLE, PASS1, PASS2, DONE
  } state_t;

  state_t state;
  logic [WIDTH-1:0] ra, rb, rs, rt;
  logic [WIDTH-1:0] tfull;
  logic [CW-1:0] cnt;
  logic opr, carry, c1;
  logic [W-1:0] aw, bw, s;
  logic cout;
  int idx;

  fp_word_adder #(.N(W)) u_add (
    .a(aw), .b(bw), .cin(carry), .s(s), .cout(cout)
  );

  always_comb begin
    idx = int'(cnt) * W;
    aw = ra[idx +: W];
    bw = opr ? ~rb[idx +: W] : rb[idx +: W];
    if (state == PASS2) begin
      aw = rs[idx +: W];
      bw = opr ? P[idx +: W] : ~P[idx +: W];
    end
  end

  // Final T as it will look once the last word lands; used for selection.
  always_comb begin
    tfull = rt;
    tfull[WIDTH-1 -: W] = s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      rt    <= '0;
      cnt   <= '0;
      opr   <= 1'b0;
      carry <= 1'b0;
      c1    <= 1'b0;
      res   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            opr   <= op;
            cnt   <= '0;
            carry <= op;
            busy  <= 1'b1;
            state <= PASS1;
          end else begin
            state <= IDLE;
          end
        end
        PASS1: begin
          rs[idx +: W] <= s;
          carry <= cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            c1    <= cout;
            cnt   <= '0;
            carry <= ~opr;
            state <= PASS2;
          end
        end
        PASS2: begin
          rt[idx +: W] <= s;
          carry <= cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
            // sub: C1=0 is a borrow, so take S+P
            if (opr)
              res <= c1 ? rs : tfull;
            else
              res <= (c1 | cout) ? tfull : rs;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_serial.sv
// Directed + random bench for fp_addsub_serial with an
// expected-result queue popped on each done pulse.
module tb_fp_addsub_serial;
  localparam int WIDTH = 128;
  localparam logic [127:0] P =
    128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst, start, op;
  logic [127:0] a, b, res;
  logic busy, done;

  int tests = 0;
  int fails = 0;
  logic [127:0] expq[$];

  fp_addsub_serial #(.WIDTH(WIDTH), .W(32), .P(P)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .res(res), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] model(
    input bit o, input logic [127:0] x, input logic [127:0] y);
    logic [128:0] t;
    if (!o) begin
      t = {1'b0, x} + {1'b0, y};
      if (t >= {1'b0, P}) t = t - {1'b0, P};
    end else if (x >= y) begin
      t = {1'b0, x - y};
    end else begin
      t = {1'b0, x} + {1'b0, P} - {1'b0, y};
    end
    return t[127:0];
  endfunction

  function automatic logic [127:0] rnd();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom} >> 1;
    if (v == P) v = '0;
    return v;
  endfunction

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; that cycle is the start cycle.
  task automatic start_op(input bit o, input logic [127:0] x,
                          input logic [127:0] y,
                          input logic [127:0] e, input bit push);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    if (push) expq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = ~o;
    a = ~x;
    b = rnd();
  endtask

  task automatic wait_done(input string tag, input logic [15:0] pulse);
    int k = 1;
    int nbusy = 0;
    bit seen = 0;
    while (k <= 30 && !seen) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) nbusy++;
        if (k < 16 && pulse[k]) begin
          start = 1'b1;
          op = $urandom_range(0, 1) == 1;
          a = rnd();
          b = rnd();
        end
        @(negedge clk);
        start = 1'b0;
        k++;
      end
    end
    check({tag, " seen"}, 128'(seen), 128'd1);
    if (seen) begin
      check({tag, " latency"}, 128'(k), 128'd9);
      check({tag, " busy cycles"}, 128'(nbusy), 128'd8);
      check({tag, " busy at done"}, 128'(busy), 128'd0);
      if (expq.size() == 0)
        check({tag, " queue"}, 128'(expq.size()), 128'd1);
      else
        check({tag, " res"}, res, expq.pop_front());
    end
  endtask

  initial begin
    int nd;
    logic [127:0] x, y;
    bit o;
    rst = 1'b1;
    start = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset res", res, '0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset done", 128'(done), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    start_op(0, 128'd5, 128'd7, 128'd12, 1);
    wait_done("add 5+7", '0);
    @(negedge clk);
    start_op(0, P - 1, 128'd2, 128'd1, 1);
    wait_done("add wrap", '0);
    @(negedge clk);
    start_op(0, P - 1, P - 1, P - 2, 1);
    wait_done("add max", '0);
    @(negedge clk);
    start_op(1, 128'd3, 128'd5, P - 2, 1);
    wait_done("sub borrow", '0);
    @(negedge clk);
    start_op(1, 128'd9, 128'd9, 128'd0, 1);
    wait_done("sub equal", '0);
    @(negedge clk);
    start_op(1, 128'h1_0000_0000, 128'd1, 128'hFFFF_FFFF, 1);
    wait_done("sub word", '0);
    @(negedge clk);
    start_op(0, 128'd0, 128'd0, 128'd0, 1);
    wait_done("add zero", '0);
    @(negedge clk);

    start_op(1, 128'd3, 128'd5, P - 2, 1);
    wait_done("ignore start", 16'h0028);
    start_op(0, P - 1, P - 1, P - 2, 1);
    wait_done("chain", '0);
    @(negedge clk);
    check("done width", 128'(done), 128'd0);

    start_op(0, 128'd5, 128'd7, 128'd0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 128'(busy), 128'd0);
    check("abort done", 128'(done), 128'd0);
    check("abort res", res, '0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort no done", 128'(nd), 128'd0);
    start_op(0, P - 1, 128'd2, 128'd1, 1);
    wait_done("after abort", '0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      x = rnd();
      y = rnd();
      o = (i % 2) == 1;
      start_op(o, x, y, model(o, x, y), 1);
      wait_done("random", '0);
    end

    check("queue empty", 128'(expq.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
